// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    // Read-port behaviour: registered read or first-word-fall-through.
    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Transaction field widths shared with the verification environment.
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
interface sync_fifo_param_if #(
    parameter int unsigned WIDTH = fifo_pkg::DEF_WIDTH,
    parameter int unsigned DEPTH = fifo_pkg::DEF_DEPTH
);
    localparam int unsigned CW = fifo_pkg::cnt_width(DEPTH);

    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    fifo_cnt;
    logic             overflow;
    logic             underflow;

    // Side that drives requests into the FIFO.
    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, full, empty, almost_full, almost_empty, fifo_cnt, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read. Not reset.
module fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; a same-address read this cycle still sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, error pulses and
// selectable registered / first-word-fall-through read port.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter fifo_mode_e  MODE      = FIFO_STD
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_param: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic [WIDTH-1:0] dout_q, rd_data;
    logic             wr_acc, rd_acc;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Accept decisions, pointer wrap and occupancy update from registered state.
    always_comb begin
        rd_acc   = rst_n & bus.rd_en & ~empty_q;
        wr_acc   = rst_n & bus.wr_en & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State, flags derived from the next count, and the read data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= (AF_THRESH == 0);
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == CW'(DEPTH));
            empty_q  <= (cnt_d == '0);
            af_q     <= (32'(cnt_d) >= AF_THRESH);
            ae_q     <= (32'(cnt_d) <= AE_THRESH);
            ovf_q    <= bus.wr_en & ~wr_acc;
            unf_q    <= bus.rd_en & ~rd_acc;
            if (rd_acc) begin
                dout_q <= rd_data;
            end
        end
    end

    // FWFT shows the head word directly; while empty it falls back to the last
    // popped word so the output never goes X once anything has been written.
    assign bus.data_out     = (MODE == FIFO_FWFT && !empty_q) ? rd_data : dout_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.fifo_cnt     = cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: DEPTH=16 registered-read FIFO and DEPTH=5 FWFT FIFO.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) ia ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(5))  ib ();

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .MODE(FIFO_STD)) u_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .MODE(FIFO_FWFT)) u_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.data_in = '0; ia.wr_en = 1'b0; ia.rd_en = 1'b0;
        ib.data_in = '0; ib.wr_en = 1'b0; ib.rd_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset / idle state.
        chk("rst_empty", 32'(ia.empty), 1);
        chk("rst_ae", 32'(ia.almost_empty), 1);
        chk("rst_full", 32'(ia.full), 0);
        chk("rst_af", 32'(ia.almost_full), 0);
        chk("rst_cnt", 32'(ia.fifo_cnt), 0);
        chk("rst_dout", 32'(ia.data_out), 0);
        chk("rst_ovf", 32'(ia.overflow), 0);
        chk("rst_unf", 32'(ia.underflow), 0);

        // Fill with 0x01..0x10.
        ia.wr_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            ia.data_in = 8'(i);
            tick();
            chk("fill_cnt", 32'(ia.fifo_cnt), i);
            chk("fill_full", 32'(ia.full), (i == 16) ? 1 : 0);
            chk("fill_af", 32'(ia.almost_full), (i >= 14) ? 1 : 0);
            chk("fill_ae", 32'(ia.almost_empty), (i <= 2) ? 1 : 0);
        end

        // Write while full without read: single-cycle overflow.
        ia.data_in = 8'h77;
        tick();
        chk("ovf_pulse", 32'(ia.overflow), 1);
        chk("ovf_cnt", 32'(ia.fifo_cnt), 16);
        ia.wr_en = 1'b0;
        tick();
        chk("ovf_clear", 32'(ia.overflow), 0);

        // Simultaneous write+read while full.
        ia.wr_en = 1'b1; ia.rd_en = 1'b1; ia.data_in = 8'hAA;
        tick();
        chk("wr_rd_full_cnt", 32'(ia.fifo_cnt), 16);
        chk("wr_rd_full_ovf", 32'(ia.overflow), 0);
        chk("wr_rd_full_dout", 32'(ia.data_out), 32'h01);
        ia.wr_en = 1'b0;

        // Drain: 0x02..0x10 then 0xAA, valid one cycle after each read edge.
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_dout", 32'(ia.data_out), (i < 15) ? i + 2 : 32'hAA);
            chk("drain_cnt", 32'(ia.fifo_cnt), 15 - i);
        end
        chk("drain_empty", 32'(ia.empty), 1);

        // Read while empty: underflow, data held.
        tick();
        chk("unf_pulse", 32'(ia.underflow), 1);
        chk("unf_dout_hold", 32'(ia.data_out), 32'hAA);
        chk("unf_cnt", 32'(ia.fifo_cnt), 0);
        ia.rd_en = 1'b0;
        tick();
        chk("unf_clear", 32'(ia.underflow), 0);

        // Write+read while empty: write taken, read rejected.
        ia.wr_en = 1'b1; ia.rd_en = 1'b1; ia.data_in = 8'h55;
        tick();
        chk("wr_rd_empty_unf", 32'(ia.underflow), 1);
        chk("wr_rd_empty_cnt", 32'(ia.fifo_cnt), 1);
        chk("wr_rd_empty_nempty", 32'(ia.empty), 0);
        chk("wr_rd_empty_dout", 32'(ia.data_out), 32'hAA);
        ia.wr_en = 1'b0;
        tick();
        chk("rd_55", 32'(ia.data_out), 32'h55);
        chk("rd_55_cnt", 32'(ia.fifo_cnt), 0);
        ia.rd_en = 1'b0;

        // Mid-operation reset with a write pending.
        ia.wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ia.data_in = 8'(8'h30 + i);
            tick();
        end
        chk("pre_rst_cnt", 32'(ia.fifo_cnt), 7);
        rst_n = 1'b0; ia.data_in = 8'h99;
        tick();
        chk("mid_rst_cnt", 32'(ia.fifo_cnt), 0);
        chk("mid_rst_empty", 32'(ia.empty), 1);
        chk("mid_rst_ovf", 32'(ia.overflow), 0);
        chk("mid_rst_dout", 32'(ia.data_out), 0);
        rst_n = 1'b1;
        ia.data_in = 8'h41;
        tick();
        ia.data_in = 8'h42;
        tick();
        chk("post_rst_cnt", 32'(ia.fifo_cnt), 2);
        ia.wr_en = 1'b0; ia.rd_en = 1'b1;
        tick();
        chk("post_rst_rd1", 32'(ia.data_out), 32'h41);
        tick();
        chk("post_rst_rd2", 32'(ia.data_out), 32'h42);
        chk("post_rst_empty", 32'(ia.empty), 1);
        ia.rd_en = 1'b0;

        // FWFT, DEPTH=5: first word appears without rd_en.
        ib.wr_en = 1'b1; ib.data_in = 8'h11;
        tick();
        chk("fwft_first_empty", 32'(ib.empty), 0);
        chk("fwft_first_dout", 32'(ib.data_out), 32'h11);
        for (int i = 2; i <= 5; i++) begin
            ib.data_in = 8'(8'h10 + i);
            tick();
        end
        chk("fwft_full", 32'(ib.full), 1);
        chk("fwft_full_cnt", 32'(ib.fifo_cnt), 5);
        chk("fwft_head_hold", 32'(ib.data_out), 32'h11);

        // Pop three.
        ib.wr_en = 1'b0; ib.rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("fwft_pop_a", 32'(ib.data_out), 32'h11 + k);
            tick();
        end
        chk("fwft_mid_cnt", 32'(ib.fifo_cnt), 2);
        chk("fwft_mid_ae", 32'(ib.almost_empty), 1);

        // Write three more, wrapping the write pointer.
        ib.rd_en = 1'b0; ib.wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ib.data_in = 8'(8'h16 + k);
            tick();
        end
        chk("fwft_wrap_cnt", 32'(ib.fifo_cnt), 5);
        chk("fwft_wrap_af", 32'(ib.almost_full), 1);
        chk("fwft_wrap_head", 32'(ib.data_out), 32'h14);

        // Pop remaining five: 0x14..0x18.
        ib.wr_en = 1'b0; ib.rd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("fwft_pop_b", 32'(ib.data_out), 32'h14 + k);
            tick();
        end
        ib.rd_en = 1'b0;
        chk("fwft_end_empty", 32'(ib.empty), 1);
        chk("fwft_end_cnt", 32'(ib.fifo_cnt), 0);
        chk("fwft_not_x", 32'($isunknown(ib.data_out)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
